// File: rtl/qaoa_mul_pkg.sv
// Shared constants for the round-robin multiplier arbiter and its multiplier core.
package qaoa_mul_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned PROD_W_DEF  = 52;
  localparam int unsigned NUM_REQ_MAX = 8;
  localparam int unsigned PTR_W       = $clog2(NUM_REQ_MAX);
  // Widest one-hot requester tag carried through the pipeline.
  localparam int unsigned TAG_W       = NUM_REQ_MAX;

endpackage

// File: rtl/qaoa_mul_core.sv
// Registered signed multiplier: keeps the low PROD_W bits of a*b, updates only when ce=1.
module qaoa_mul_core
  import qaoa_mul_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned PROD_W = PROD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] prod
);

  logic [PROD_W-1:0] prod_q, prod_d;

  // Low bits of a product depend only on the low bits of the sign-extended operands.
  always_comb begin
    prod_d = prod_q;
    if (ce) begin
      prod_d = PROD_W'($signed(a)) * PROD_W'($signed(b));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/qaoa_mul_arbiter.sv
// Round-robin arbiter sharing one two-stage signed multiplier among NUM_REQ requesters.
// Define QAOA_MUL_ARB_STATS_EN to add the 32-bit issue_count handshake counter.
module qaoa_mul_arbiter
  import qaoa_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PROD_W  = PROD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]         rsp_data
`ifdef QAOA_MUL_ARB_STATS_EN
  ,
  output logic [31:0]               issue_count
`endif
);

  localparam int unsigned IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0] tag1_q, tag1_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] rot_req;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx, gnt_sum, nxt_idx;
  logic [DATA_W-1:0]  a_sel, b_sel;

  // Rotate the requests so the pointer sits at bit 0, then take the first set bit.
  always_comb begin
    rot_req   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_sum   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && rot_req[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = IDX_W'(ptr_q) + IDX_W'(k);
        gnt_idx   = (gnt_sum >= IDX_W'(NUM_REQ)) ? gnt_sum - IDX_W'(NUM_REQ) : gnt_sum;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ce && gnt_found && (gnt_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        a_sel        = req_a[i*DATA_W +: DATA_W];
        b_sel        = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // rsp_valid clears on ce=0 edges so each result strobes exactly one clock.
  always_comb begin
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    tag1_d      = tag1_q;
    rsp_valid_d = '0;
    nxt_idx     = gnt_idx + IDX_W'(1);
    if (ce) begin
      tag1_d      = req_ready;
      rsp_valid_d = tag1_q;
      if (gnt_found) begin
        a_d   = a_sel;
        b_d   = b_sel;
        ptr_d = (nxt_idx == IDX_W'(NUM_REQ)) ? '0 : nxt_idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag1_q      <= '0;
      rsp_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag1_q      <= tag1_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Product only advances with a real operation, so rsp_data holds across bubbles.
  qaoa_mul_core #(
    .DATA_W (DATA_W),
    .PROD_W (PROD_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .ce    (ce && (|tag1_q)),
    .a     (a_q),
    .b     (b_q),
    .prod  (rsp_data)
  );

  assign rsp_valid = rsp_valid_q;

`ifdef QAOA_MUL_ARB_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q + 32'(|req_ready);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_qaoa_mul_arbiter.sv
// Randomized self-checking bench for qaoa_mul_arbiter against a queue-based reference model.
module tb_qaoa_mul_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 52;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]  rsp_valid;
  logic [PW-1:0] rsp_data;
`ifdef QAOA_MUL_ARB_STATS_EN
  logic [31:0]   issue_count;
`endif

  qaoa_mul_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PROD_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
`ifdef QAOA_MUL_ARB_STATS_EN
    ,
    .issue_count (issue_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: pending operations with remaining ce edges until they emerge.
  typedef struct {
    int            idx;
    int            left;
    logic [PW-1:0] prod;
  } op_t;

  op_t           pend[$];
  int            ptr_m;
  logic [N-1:0]  exp_rv;
  logic [PW-1:0] exp_rd;
  logic [31:0]   issue_m;
  logic [DW-1:0] a_arr[N];
  logic [DW-1:0] b_arr[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint      pa, pb;
    logic [63:0] full;
    pa   = longint'($signed(a));
    pb   = longint'($signed(b));
    full = pa * pb;
    return full[PW-1:0];
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check grant, step the model at posedge, check response.
  task automatic cycle(input logic [N-1:0] v, input logic c);
    int           g;
    op_t          e;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    ce        = c;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = a_arr[i];
      req_b[i*DW +: DW] = b_arr[i];
    end
    #2;
    g         = c ? pick(v) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    exp_rv = '0;
    if (c) begin
      foreach (pend[j]) pend[j].left--;
      if (pend.size() > 0 && pend[0].left == 0) begin
        e = pend.pop_front();
        exp_rv[e.idx] = 1'b1;
        exp_rd = e.prod;
      end
    end
    if (g >= 0) begin
      pend.push_back('{idx: g, left: 1, prod: ref_mul(a_arr[g], b_arr[g])});
      ptr_m   = (g + 1) % N;
      issue_m = issue_m + 32'd1;
    end
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("rsp_data", 64'(rsp_data), 64'(exp_rd));
`ifdef QAOA_MUL_ARB_STATS_EN
    check("issue_count", 64'(issue_count), 64'(issue_m));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    ce        = 1'b1;
    req_valid = '0;
    pend.delete();
    ptr_m   = 0;
    exp_rv  = '0;
    exp_rd  = '0;
    issue_m = '0;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
`ifdef QAOA_MUL_ARB_STATS_EN
    check("rst_issue_count", 64'(issue_count), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = DW'(i + 1);
      b_arr[i] = DW'(10 * (i + 1));
    end
    do_reset();

    // Single request with a negative operand.
    a_arr[0] = -32'sd3;
    b_arr[0] = 32'sd7;
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    check("neg21_data", 64'(rsp_data), 64'h000F_FFFF_FFFF_FFEB);
    check("neg21_valid", 64'(rsp_valid), 64'h1);
    cycle(4'b0000, 1'b1);

    // Extremes.
    a_arr[0] = 32'h8000_0000;
    b_arr[0] = 32'h8000_0000;
    cycle(4'b0001, 1'b1);
    a_arr[0] = 32'h7FFF_FFFF;
    b_arr[0] = 32'hFFFF_FFFF;
    cycle(4'b0001, 1'b1);
    check("min_sq", 64'(rsp_data), 64'h0);
    cycle(4'b0000, 1'b1);
    check("max_neg1", 64'(rsp_data), 64'h000F_FFFF_8000_0001);

    // Everyone requesting continuously.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = DW'(i + 2);
      b_arr[i] = DW'(-(i + 5));
    end
    repeat (7) cycle(4'b1111, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);

    // Stall between handshake and result.
    cycle(4'b0100, 1'b1);
    repeat (3) cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Pointer at 2 with requesters 1 and 3 valid.
    do_reset();
    cycle(4'b0010, 1'b1);
    cycle(4'b1010, 1'b1);
    check("p2_first_is_3", 64'(pend[pend.size()-1].idx), 64'd3);
    cycle(4'b1010, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);

    // Reset with two operations in flight.
    cycle(4'b0001, 1'b1);
    cycle(4'b0010, 1'b1);
    do_reset();
    repeat (3) cycle(4'b0000, 1'b1);
    cycle(4'b1111, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       a_arr[i] = 32'h8000_0000;
          1:       a_arr[i] = 32'h7FFF_FFFF;
          default: a_arr[i] = $urandom;
        endcase
        b_arr[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0));
      end
    end
    repeat (3) cycle(4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
